// File: rtl/alu_serial_seq.sv
// alu_serial_seq
//   Bit-serial sequencer for the external 1-bit ALU slice of the 16-bit
//   CPU datapath. One WIDTH-bit operation is accepted over a valid/ready
//   request and fed through the slice LSB first, one bit per cycle, with
//   the carry registered between cycles. The result and its Z/C/V flags
//   are returned over a valid/ready response.
//
// Ports
//   clk, rst_n          clock (rising edge), synchronous active-low reset
//   req_valid/ready     request handshake (ready only while IDLE)
//   req_a, req_b        operands
//   req_ctl             {ainvert, bnegate, op[1:0]}; op 11 selects SLT
//   rsp_valid/ready     response handshake
//   rsp_result          result word
//   rsp_zero            rsp_result == 0
//   rsp_carry           carry out of the MSB slice
//   rsp_ovf             signed overflow, cin_msb ^ cout_msb
//   slice_*             drive/return of the external 1-bit slice
module alu_serial_seq #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [3:0]       req_ctl,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic             rsp_carry,
    output logic             rsp_ovf,
    output logic             slice_a,
    output logic             slice_b,
    output logic             slice_cin,
    output logic             slice_ainvert,
    output logic             slice_bnegate,
    output logic [1:0]       slice_op,
    output logic             slice_less,
    input  logic             slice_result,
    input  logic             slice_cout
);

    typedef enum logic [1:0] {IDLE, RUN, RESP} state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state_q;
    logic [WIDTH-1:0] a_q, b_q, res_q;
    logic [3:0]       ctl_q;
    logic [CNT_W-1:0] cnt_q;
    logic             carry_q, cin_msb_q;
    logic             req_ready_q, rsp_valid_q;
    logic [WIDTH-1:0] rsp_result_q;
    logic             rsp_zero_q, rsp_carry_q, rsp_ovf_q;

    logic             is_slt;
    logic             ovf_d, less_d, zero_d;
    logic [WIDTH-1:0] result_d;

    assign is_slt = (ctl_q[1:0] == 2'b11);

    // Slice is always driven from the latched operands; only meaningful in RUN.
    // SLT runs the slice as a subtract, the less bit is formed here afterwards.
    assign slice_a       = a_q[cnt_q];
    assign slice_b       = b_q[cnt_q];
    assign slice_cin     = carry_q;
    assign slice_ainvert = ctl_q[3];
    assign slice_bnegate = ctl_q[2];
    assign slice_op      = is_slt ? 2'b10 : ctl_q[1:0];
    assign slice_less    = 1'b0;

    // Final word and flags, evaluated in the first RESP cycle when res_q,
    // carry_q (cout of MSB) and cin_msb_q are all complete.
    always_comb begin
        ovf_d    = cin_msb_q ^ carry_q;
        less_d   = res_q[WIDTH-1] ^ ovf_d;
        result_d = res_q;
        if (is_slt) begin
            result_d = {{(WIDTH-1){1'b0}}, less_d};
        end
        zero_d = (result_d == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            req_ready_q  <= 1'b1;
            rsp_valid_q  <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            res_q        <= '0;
            ctl_q        <= '0;
            cnt_q        <= '0;
            carry_q      <= 1'b0;
            cin_msb_q    <= 1'b0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_carry_q  <= 1'b0;
            rsp_ovf_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        a_q         <= req_a;
                        b_q         <= req_b;
                        ctl_q       <= req_ctl;
                        carry_q     <= req_ctl[2];
                        cnt_q       <= '0;
                        req_ready_q <= 1'b0;
                        state_q     <= RUN;
                    end
                end
                RUN: begin
                    res_q[cnt_q] <= slice_result;
                    carry_q      <= slice_cout;
                    if (cnt_q == LAST) begin
                        cin_msb_q <= carry_q;
                        state_q   <= RESP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RESP: begin
                    // First cycle registers the response; it is then held
                    // unchanged until the consumer takes it.
                    if (!rsp_valid_q) begin
                        rsp_result_q <= result_d;
                        rsp_zero_q   <= zero_d;
                        rsp_carry_q  <= carry_q;
                        rsp_ovf_q    <= ovf_d;
                        rsp_valid_q  <= 1'b1;
                    end else if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_zero   = rsp_zero_q;
    assign rsp_carry  = rsp_carry_q;
    assign rsp_ovf    = rsp_ovf_q;

endmodule

// File: tb/tb_alu_serial_seq.sv
// Bench for alu_serial_seq: models the external 1-bit slice, drives directed
// operations and checks every response cycle against a word-level model.
module tb_alu_serial_seq;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req_valid, req_ready;
    logic [W-1:0] req_a, req_b;
    logic [3:0]   req_ctl;
    logic         rsp_valid, rsp_ready;
    logic [W-1:0] rsp_result;
    logic         rsp_zero, rsp_carry, rsp_ovf;
    logic         slice_a, slice_b, slice_cin, slice_ainvert, slice_bnegate, slice_less;
    logic [1:0]   slice_op;
    logic         slice_result, slice_cout;

    int n_vec = 0;
    int n_err = 0;
    int n_acc = 0;

    typedef struct {
        logic [W-1:0] res;
        logic         z, c, v;
        logic [W-1:0] lit;
        bit           has_lit;
        logic [2:0]   lflags;   // {z,c,v}
        bit           has_lf;
    } exp_t;

    exp_t exp_q[$];

    alu_serial_seq #(.WIDTH(16), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_ctl(req_ctl),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero),
        .rsp_carry(rsp_carry), .rsp_ovf(rsp_ovf),
        .slice_a(slice_a), .slice_b(slice_b), .slice_cin(slice_cin),
        .slice_ainvert(slice_ainvert), .slice_bnegate(slice_bnegate),
        .slice_op(slice_op), .slice_less(slice_less),
        .slice_result(slice_result), .slice_cout(slice_cout)
    );

    always #5 clk = ~clk;

    // Behavioural 1-bit ALU slice
    logic ae, be, sum_b;
    always_comb begin
        ae         = slice_a ^ slice_ainvert;
        be         = slice_b ^ slice_bnegate;
        sum_b      = ae ^ be ^ slice_cin;
        slice_cout = (ae & be) | (ae & slice_cin) | (be & slice_cin);
        case (slice_op)
            2'b00:   slice_result = ae & be;
            2'b01:   slice_result = ae | be;
            2'b10:   slice_result = sum_b;
            default: slice_result = slice_less;
        endcase
    end

    // Word-level reference
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] ctl);
        exp_t e;
        logic [W-1:0] aa, bb, s;
        logic [W:0]   sum;
        logic         v;
        aa  = ctl[3] ? ~a : a;
        bb  = ctl[2] ? ~b : b;
        sum = {1'b0, aa} + {1'b0, bb} + {{W{1'b0}}, ctl[2]};
        s   = sum[W-1:0];
        v   = (aa[W-1] == bb[W-1]) && (s[W-1] != aa[W-1]);
        case (ctl[1:0])
            2'b00:   e.res = aa & bb;
            2'b01:   e.res = aa | bb;
            2'b10:   e.res = s;
            default: e.res = {{(W-1){1'b0}}, s[W-1] ^ v};
        endcase
        e.z = (e.res == '0);
        e.c = sum[W];
        e.v = v;
        e.lit = '0; e.has_lit = 0; e.lflags = '0; e.has_lf = 0;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (rst_n && req_valid && req_ready) n_acc++;
    end

    // Response checker: every cycle a response is presented
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && rsp_valid === 1'b1) begin
            chk("req_ready_during_rsp", req_ready, 0);
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp_valid", rsp_valid, 0);
            end else begin
                e = exp_q[0];
                chk("result", rsp_result, e.res);
                chk("zero", rsp_zero, e.z);
                chk("carry", rsp_carry, e.c);
                chk("ovf", rsp_ovf, e.v);
                if (e.has_lit) chk("lit_result", rsp_result, e.lit);
                if (e.has_lf) begin
                    chk("lit_zero", rsp_zero, e.lflags[2]);
                    chk("lit_carry", rsp_carry, e.lflags[1]);
                    chk("lit_ovf", rsp_ovf, e.lflags[0]);
                end
                if (rsp_ready) exp_q.delete(0);
            end
        end
    end

    task automatic wait_rsp(input int exp_lat);
        int lat = 0;
        while (rsp_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        chk("latency", lat, exp_lat);
    endtask

    task automatic wait_drop();
        int k = 0;
        while (rsp_valid !== 1'b0 && k < 40) begin
            @(posedge clk); #1; k++;
        end
        chk("rsp_valid_drop", rsp_valid, 0);
    endtask

    task automatic wait_ready();
        int k = 0;
        while (req_ready !== 1'b1 && k < 50) begin
            @(posedge clk); #1; k++;
        end
        chk("req_ready_before_accept", req_ready, 1);
    endtask

    // Called #1 after a rising edge.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] ctl,
                          input logic [W-1:0] lr, input bit hl, input logic [2:0] lf, input bit hf);
        exp_t e;
        e = model(a, b, ctl);
        e.lit = lr; e.has_lit = hl; e.lflags = lf; e.has_lf = hf;
        req_a = a; req_b = b; req_ctl = ctl; req_valid = 1'b1;
        wait_ready();
        exp_q.push_back(e);
        @(posedge clk); #1;
        req_valid = 1'b0;
        wait_rsp(17);
        wait_drop();
    endtask

    // Directed table: a, b, ctl, literal result, literal {z,c,v}, flags known
    logic [W-1:0] ta[11] = '{16'h7FFF, 16'h0005, 16'h8000, 16'h0001, 16'h00FF, 16'hA5A5,
                             16'h1200, 16'hFFFF, 16'h0000, 16'h8000, 16'hF0F0};
    logic [W-1:0] tb[11] = '{16'h0001, 16'h0005, 16'h0001, 16'h8000, 16'h0F0F, 16'h0FF0,
                             16'h0034, 16'h0001, 16'h0001, 16'h0001, 16'hFF00};
    logic [3:0]   tc[11] = '{4'b0010, 4'b0110, 4'b0111, 4'b0111, 4'b1100, 4'b0000,
                             4'b0001, 4'b0010, 4'b0110, 4'b0110, 4'b1000};
    logic [W-1:0] tr[11] = '{16'h8000, 16'h0000, 16'h0001, 16'h0000, 16'hF000, 16'h05A0,
                             16'h1234, 16'h0000, 16'hFFFF, 16'h7FFF, 16'h0F00};
    logic [2:0]   tf[11] = '{3'b001, 3'b110, 3'b000, 3'b000, 3'b000, 3'b000,
                             3'b000, 3'b110, 3'b000, 3'b011, 3'b000};
    bit           th[11] = '{1, 1, 0, 0, 0, 0, 0, 1, 1, 1, 0};

    initial begin
        exp_t e1, e2;
        int   snap;
        rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
        req_a = '0; req_b = '0; req_ctl = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_req_ready", req_ready, 1);
        chk("reset_result", rsp_result, 0);
        chk("reset_flags", {rsp_zero, rsp_carry, rsp_ovf}, 0);

        for (int i = 0; i < 11; i++) begin
            run_op(ta[i], tb[i], tc[i], tr[i], 1'b1, tf[i], th[i]);
        end

        // Backpressure with a second request held pending
        rsp_ready = 1'b0;
        e1 = model(16'h1234, 16'h1111, 4'b0010);
        e1.lit = 16'h2345; e1.has_lit = 1;
        e2 = model(16'h0100, 16'h0001, 4'b0110);
        e2.lit = 16'h00FF; e2.has_lit = 1;
        req_a = 16'h1234; req_b = 16'h1111; req_ctl = 4'b0010; req_valid = 1'b1;
        wait_ready();
        exp_q.push_back(e1);
        @(posedge clk); #1;
        req_a = 16'h0100; req_b = 16'h0001; req_ctl = 4'b0110;
        wait_rsp(17);
        snap = n_acc;
        repeat (5) begin
            @(posedge clk); #1;
            chk("bp_rsp_held", rsp_valid, 1);
            chk("bp_no_accept", n_acc, snap);
        end
        rsp_ready = 1'b1;
        exp_q.push_back(e2);
        @(posedge clk); #1;
        chk("bp_exit_rsp_valid", rsp_valid, 0);
        chk("bp_exit_req_ready", req_ready, 1);
        chk("bp_exit_no_accept", n_acc, snap);
        @(posedge clk); #1;
        chk("bp_second_accept", n_acc, snap + 1);
        req_valid = 1'b0;
        wait_rsp(17);
        wait_drop();

        // Reset in the middle of RUN (bit index 7)
        req_a = 16'h00FF; req_b = 16'h0001; req_ctl = 4'b0010; req_valid = 1'b1;
        wait_ready();
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        chk("abort_rsp_valid", rsp_valid, 0);
        chk("abort_req_ready", req_ready, 1);
        repeat (25) begin
            @(posedge clk); #1;
            chk("abort_no_rsp", rsp_valid, 0);
        end
        run_op(16'h0001, 16'h0001, 4'b0010, 16'h0002, 1'b1, 3'b000, 1'b1);

        chk("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
